// File: rtl/alu_seq_pkg.sv
// Shared operation codes for the push-button ALU sequencer.
// The values are also the encoding of the last_op output.
package alu_seq_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;

endpackage

// File: rtl/pb_conditioner.sv
// Raw push-button conditioning: a synchroniser, then a debouncer, then a rising-edge detector.
// Each debounced press gives a single one-cycle pulse.
module pb_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   deb;
  logic                   deb_q;

  assign s = sync[SYNC_STAGES-1];

  // NOTE: state registers use non-blocking assignments, so each flop samples the value
  // that the previous stage held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], raw};
      deb_q <= deb;
      if (s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = deb;
  assign press = deb & ~deb_q;

endmodule

// File: rtl/pushbutton_alu_seq.sv
// Two-button AND/ADD unit with a registered result, a carry flag and a one-cycle valid pulse.
// In accumulate mode the stored result is used in place of operand A.
module pushbutton_alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             LEFT_pushbutton,
  input  logic             RIGHT_pushbutton,
  input  logic             ACC_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             valid,
  output logic [1:0]       last_op
);

  logic             left_press;
  logic             right_press;
  logic             unused_left_level;
  logic             unused_right_level;
  logic [WIDTH-1:0] x;
  logic [WIDTH:0]   sum;

  pb_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_left (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (LEFT_pushbutton),
    .level (unused_left_level),
    .press (left_press)
  );

  pb_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_right (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (RIGHT_pushbutton),
    .level (unused_right_level),
    .press (right_press)
  );

  assign x   = ACC_mode ? result : A;
  assign sum = {1'b0, x} + {1'b0, B};

  // Pressing both buttons in the same cycle clears the result.
  // A press on one button alone runs its own operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      carry   <= 1'b0;
      valid   <= 1'b0;
      last_op <= OP_NONE;
    end else begin
      valid <= left_press | right_press;
      if (left_press && right_press) begin
        result  <= '0;
        carry   <= 1'b0;
        last_op <= OP_NONE;
      end else if (left_press) begin
        result  <= x & B;
        carry   <= 1'b0;
        last_op <= OP_AND;
      end else if (right_press) begin
        result  <= sum[WIDTH-1:0];
        carry   <= sum[WIDTH];
        last_op <= OP_ADD;
      end
    end
  end

endmodule
